// File: rtl/pmp_fault_unit.sv
// Turns PMP checker failures into a RISC-V access-fault record for the trap logic.
// The lowest-index failing channel wins. A later fault while one is pending only sets lost_fault.
module pmp_fault_unit #(
    parameter int REQ_CHANNEL_NUM = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16,
    localparam int CHAN_W         = (REQ_CHANNEL_NUM > 1) ? $clog2(REQ_CHANNEL_NUM) : 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [REQ_CHANNEL_NUM-1:0]                  v_req_valid,
    input  logic [REQ_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  v_req_addr,
    input  logic [REQ_CHANNEL_NUM-1:0][1:0]             v_req_mode,
    input  logic [REQ_CHANNEL_NUM-1:0]                  v_pass,
    input  logic                                        flush,
    input  logic                                        cnt_clr,
    output logic [REQ_CHANNEL_NUM-1:0]                  v_ok,
    output logic                                        busy,
    output logic                                        exc_valid,
    input  logic                                        exc_ready,
    output logic [3:0]                                  exc_cause,
    output logic [ADDR_WIDTH-1:0]                       exc_tval,
    output logic [CHAN_W-1:0]                           exc_chan,
    output logic [CNT_WIDTH-1:0]                        fault_cnt,
    output logic                                        lost_fault
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [3:0]                 cause_q, cause_d;
    logic [ADDR_WIDTH-1:0]      tval_q, tval_d;
    logic [CHAN_W-1:0]          chan_q, chan_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       lost_q, lost_d;

    logic [REQ_CHANNEL_NUM-1:0] fault_vec;
    logic                       any_fault;
    logic [CHAN_W-1:0]          sel_chan;
    logic [ADDR_WIDTH-1:0]      sel_addr;
    logic [1:0]                 sel_mode;
    logic [3:0]                 sel_cause;
    logic                       capture;
    logic                       lost_evt;

    assign busy      = (state_q == PEND);
    assign exc_valid = busy;

    // Mode 00 marks an idle slot, so it neither faults nor reports ok.
    for (genvar gi = 0; gi < REQ_CHANNEL_NUM; gi++) begin : g_chan
        assign fault_vec[gi] = v_req_valid[gi] & (v_req_mode[gi] != 2'b00) & ~v_pass[gi];
        assign v_ok[gi]      = v_req_valid[gi] & (v_req_mode[gi] != 2'b00) & v_pass[gi] & ~busy;
    end

    assign any_fault = |fault_vec;

    // Scan from the top so the lowest failing index is the last one written.
    always_comb begin
        sel_chan = '0;
        sel_addr = '0;
        sel_mode = 2'b00;
        for (int i = REQ_CHANNEL_NUM - 1; i >= 0; i--) begin
            if (fault_vec[i]) begin
                sel_chan = CHAN_W'(i);
                sel_addr = v_req_addr[i];
                sel_mode = v_req_mode[i];
            end
        end
    end

    always_comb begin
        case (sel_mode)
            2'b01:   sel_cause = 4'd5;
            2'b10:   sel_cause = 4'd7;
            2'b11:   sel_cause = 4'd1;
            default: sel_cause = 4'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        lost_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_fault && !flush) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                lost_evt = any_fault;
                if (flush || exc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cause_d = cause_q;
        tval_d  = tval_q;
        chan_d  = chan_q;
        if (capture) begin
            cause_d = sel_cause;
            tval_d  = sel_addr;
            chan_d  = sel_chan;
        end
    end

    // A capture in the clear cycle counts as the first event after the clear.
    always_comb begin
        cnt_d = cnt_q;
        if (capture) begin
            if (cnt_clr) begin
                cnt_d = CNT_WIDTH'(1);
            end else if (!(&cnt_q)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    always_comb begin
        lost_d = lost_q;
        if (lost_evt) begin
            lost_d = 1'b1;
        end else if (cnt_clr) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cause_q <= '0;
            tval_q  <= '0;
            chan_q  <= '0;
            cnt_q   <= '0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            lost_q  <= lost_d;
        end
    end

    assign exc_cause  = cause_q;
    assign exc_tval   = tval_q;
    assign exc_chan   = chan_q;
    assign fault_cnt  = cnt_q;
    assign lost_fault = lost_q;

endmodule

// File: tb/tb_pmp_fault_unit.sv
// Self-checking bench for pmp_fault_unit: directed scenarios plus randomized traffic against a reference model.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_pmp_fault_unit;
    localparam int NCH = 3;
    localparam int AW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst_n;
    logic [NCH-1:0]           v_req_valid;
    logic [NCH-1:0][AW-1:0]   v_req_addr;
    logic [NCH-1:0][1:0]      v_req_mode;
    logic [NCH-1:0]           v_pass;
    logic                     flush, cnt_clr, exc_ready;

    logic [NCH-1:0]           v_ok;
    logic                     busy, exc_valid, lost_fault;
    logic [3:0]               exc_cause;
    logic [AW-1:0]            exc_tval;
    logic [1:0]               exc_chan;
    logic [15:0]              fault_cnt;

    logic [NCH-1:0]           s_v_ok;
    logic                     s_busy, s_exc_valid, s_lost_fault;
    logic [3:0]               s_exc_cause;
    logic [AW-1:0]            s_exc_tval;
    logic [1:0]               s_exc_chan;
    logic [1:0]               s_fault_cnt;

    pmp_fault_unit #(.REQ_CHANNEL_NUM(NCH), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .v_req_valid(v_req_valid), .v_req_addr(v_req_addr),
        .v_req_mode(v_req_mode), .v_pass(v_pass), .flush(flush), .cnt_clr(cnt_clr),
        .v_ok(v_ok), .busy(busy), .exc_valid(exc_valid), .exc_ready(exc_ready),
        .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_chan(exc_chan),
        .fault_cnt(fault_cnt), .lost_fault(lost_fault)
    );

    pmp_fault_unit #(.REQ_CHANNEL_NUM(NCH), .ADDR_WIDTH(AW), .CNT_WIDTH(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .v_req_valid(v_req_valid), .v_req_addr(v_req_addr),
        .v_req_mode(v_req_mode), .v_pass(v_pass), .flush(flush), .cnt_clr(cnt_clr),
        .v_ok(s_v_ok), .busy(s_busy), .exc_valid(s_exc_valid), .exc_ready(exc_ready),
        .exc_cause(s_exc_cause), .exc_tval(s_exc_tval), .exc_chan(s_exc_chan),
        .fault_cnt(s_fault_cnt), .lost_fault(s_lost_fault)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic          m_pend;
    logic [3:0]    m_cause;
    logic [AW-1:0] m_tval;
    logic [1:0]    m_chan;
    int            m_cnt, m_cnt_s;
    logic          m_lost;

    function automatic logic [3:0] cause_of(input logic [1:0] md);
        case (md)
            2'b01:   return 4'd5;
            2'b10:   return 4'd7;
            2'b11:   return 4'd1;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [NCH-1:0] exp_vok();
        logic [NCH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++)
            r[i] = v_req_valid[i] && (v_req_mode[i] != 2'b00) && v_pass[i] && !m_pend;
        return r;
    endfunction

    task automatic model_reset();
        m_pend = 1'b0; m_cause = '0; m_tval = '0; m_chan = '0;
        m_cnt = 0; m_cnt_s = 0; m_lost = 1'b0;
    endtask

    task automatic model_edge();
        int  first;
        bit  cap, lost;
        first = -1;
        for (int i = 0; i < NCH; i++)
            if (first < 0 && v_req_valid[i] && v_req_mode[i] != 2'b00 && !v_pass[i]) first = i;
        cap  = !m_pend && (first >= 0) && !flush;
        lost = m_pend && (first >= 0);
        if (cnt_clr) begin m_cnt = 0; m_cnt_s = 0; m_lost = 1'b0; end
        if (cap) begin
            m_chan  = 2'(first);
            m_tval  = v_req_addr[first];
            m_cause = cause_of(v_req_mode[first]);
            m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            m_cnt_s = (m_cnt_s < 3) ? m_cnt_s + 1 : m_cnt_s;
        end
        if (lost) m_lost = 1'b1;
        if (m_pend && (flush || exc_ready)) m_pend = 1'b0;
        else if (cap) m_pend = 1'b1;
    endtask

    task automatic idle_inputs();
        v_req_valid = '0; v_req_addr = '0; v_req_mode = '0; v_pass = '0;
        flush = 1'b0; cnt_clr = 1'b0; exc_ready = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic vld, input logic [1:0] md,
                          input logic [AW-1:0] addr, input logic pass);
        v_req_valid[i] = vld; v_req_mode[i] = md; v_req_addr[i] = addr; v_pass[i] = pass;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk); @(posedge clk);
        to_neg();
        checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL reset_exc_valid: got %0b want 0", exc_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (exc_cause !== 4'd0 || exc_tval !== '0 || exc_chan !== 2'd0) begin errors++;
            $display("FAIL reset_record: got cause=%0d tval=%h chan=%0d want 0 0 0", exc_cause, exc_tval, exc_chan); end
        checks++; if (fault_cnt !== 16'd0 || lost_fault !== 1'b0) begin errors++;
            $display("FAIL reset_counters: got cnt=%0d lost=%0b want 0 0", fault_cnt, lost_fault); end
        checks++; if (v_ok !== 3'b000) begin errors++; $display("FAIL reset_v_ok: got %b want 000", v_ok); end
        rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_fault();
        idle_inputs();
        set_ch(1, 1'b1, 2'b01, 32'h8000_0010, 1'b0);
        v_pass[0] = 1'b1; v_pass[2] = 1'b1;
        to_neg();
        checks++; if (v_ok !== 3'b000) begin errors++; $display("FAIL single_v_ok: got %b want 000", v_ok); end
        tick();
        idle_inputs(); exc_ready = 1'b1;
        to_neg();
        checks++; if (exc_valid !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL single_valid: got valid=%0b busy=%0b want 1 1", exc_valid, busy); end
        checks++; if (exc_cause !== 4'd5) begin errors++; $display("FAIL single_cause: got %0d want 5", exc_cause); end
        checks++; if (exc_tval !== 32'h8000_0010) begin errors++; $display("FAIL single_tval: got %h want 80000010", exc_tval); end
        checks++; if (exc_chan !== 2'd1) begin errors++; $display("FAIL single_chan: got %0d want 1", exc_chan); end
        checks++; if (fault_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", fault_cnt); end
        tick();
        idle_inputs();
        to_neg();
        checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %0b want 0", exc_valid); end
        tick();
        $display("test_single_fault done");
    endtask

    task automatic test_priority();
        idle_inputs();
        set_ch(0, 1'b1, 2'b11, 32'h100, 1'b0);
        set_ch(1, 1'b1, 2'b10, 32'h200, 1'b0);
        set_ch(2, 1'b1, 2'b01, 32'h300, 1'b0);
        tick();
        idle_inputs(); exc_ready = 1'b1;
        to_neg();
        checks++; if (exc_chan !== 2'd0 || exc_cause !== 4'd1 || exc_tval !== 32'h100) begin errors++;
            $display("FAIL prio_record: got chan=%0d cause=%0d tval=%h want 0 1 100", exc_chan, exc_cause, exc_tval); end
        checks++; if (lost_fault !== 1'b0) begin errors++; $display("FAIL prio_lost: got %0b want 0", lost_fault); end
        tick();
        idle_inputs();
        $display("test_priority done");
    endtask

    task automatic test_busy_lost();
        idle_inputs();
        set_ch(0, 1'b1, 2'b01, 32'h200, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            set_ch(2, 1'b1, 2'b10, 32'h400, 1'b0);
            set_ch(1, 1'b1, 2'b01, 32'h500, 1'b1);
            to_neg();
            checks++; if (busy !== 1'b1 || v_ok !== 3'b000) begin errors++;
                $display("FAIL busy_stall: got busy=%0b v_ok=%b want 1 000", busy, v_ok); end
            checks++; if (exc_chan !== 2'd0 || exc_cause !== 4'd5 || exc_tval !== 32'h200) begin errors++;
                $display("FAIL busy_record: got chan=%0d cause=%0d tval=%h want 0 5 200", exc_chan, exc_cause, exc_tval); end
            checks++; if (fault_cnt !== 16'(m_cnt)) begin errors++;
                $display("FAIL busy_cnt: got %0d want %0d", fault_cnt, m_cnt); end
            checks++; if (lost_fault !== (k > 0)) begin errors++;
                $display("FAIL busy_lost: got %0b want %0b", lost_fault, (k > 0)); end
            tick();
        end
        idle_inputs(); exc_ready = 1'b1;
        tick();
        idle_inputs();
        $display("test_busy_lost done");
    endtask

    task automatic test_flush();
        idle_inputs(); cnt_clr = 1'b1;
        tick();
        idle_inputs();
        to_neg();
        checks++; if (fault_cnt !== 16'd0 || lost_fault !== 1'b0) begin errors++;
            $display("FAIL clr: got cnt=%0d lost=%0b want 0 0", fault_cnt, lost_fault); end
        set_ch(0, 1'b1, 2'b01, 32'h10, 1'b0); flush = 1'b1;
        tick();
        idle_inputs();
        to_neg();
        checks++; if (exc_valid !== 1'b0 || fault_cnt !== 16'd0) begin errors++;
            $display("FAIL idle_flush: got valid=%0b cnt=%0d want 0 0", exc_valid, fault_cnt); end
        set_ch(1, 1'b1, 2'b11, 32'h20, 1'b0);
        tick();
        idle_inputs();
        flush = 1'b1; exc_ready = 1'b1;
        set_ch(0, 1'b1, 2'b10, 32'h30, 1'b0);
        to_neg();
        checks++; if (exc_valid !== 1'b1 || exc_cause !== 4'd1) begin errors++;
            $display("FAIL flush_pre: got valid=%0b cause=%0d want 1 1", exc_valid, exc_cause); end
        tick();
        idle_inputs();
        to_neg();
        checks++; if (exc_valid !== 1'b0 || fault_cnt !== 16'd1 || lost_fault !== 1'b1) begin errors++;
            $display("FAIL flush_hs: got valid=%0b cnt=%0d lost=%0b want 0 1 1", exc_valid, fault_cnt, lost_fault); end
        set_ch(2, 1'b1, 2'b01, 32'h40, 1'b0);
        tick();
        idle_inputs(); flush = 1'b1;
        tick();
        idle_inputs();
        to_neg();
        checks++; if (exc_valid !== 1'b0 || fault_cnt !== 16'd2) begin errors++;
            $display("FAIL flush_pend: got valid=%0b cnt=%0d want 0 2", exc_valid, fault_cnt); end
        tick();
        $display("test_flush done");
    endtask

    task automatic test_mode00();
        idle_inputs();
        set_ch(0, 1'b1, 2'b00, 32'h1000, 1'b0);
        set_ch(1, 1'b1, 2'b01, 32'h1004, 1'b0);
        set_ch(2, 1'b1, 2'b10, 32'h1008, 1'b0);
        to_neg();
        checks++; if (v_ok !== 3'b000) begin errors++; $display("FAIL mode00_v_ok: got %b want 000", v_ok); end
        tick();
        idle_inputs(); exc_ready = 1'b1;
        to_neg();
        checks++; if (exc_chan !== 2'd1 || exc_cause !== 4'd5 || exc_tval !== 32'h1004) begin errors++;
            $display("FAIL mode00_record: got chan=%0d cause=%0d tval=%h want 1 5 1004", exc_chan, exc_cause, exc_tval); end
        tick();
        idle_inputs();
        $display("test_mode00 done");
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        set_ch(0, 1'b1, 2'b01, 32'h50, 1'b0);
        tick();
        idle_inputs(); exc_ready = 1'b1;
        set_ch(2, 1'b1, 2'b10, 32'h60, 1'b0);
        tick();
        idle_inputs();
        set_ch(2, 1'b1, 2'b10, 32'h60, 1'b0);
        set_ch(1, 1'b1, 2'b11, 32'h70, 1'b1);
        to_neg();
        checks++; if (exc_valid !== 1'b0 || v_ok !== 3'b010) begin errors++;
            $display("FAIL b2b_gap: got valid=%0b v_ok=%b want 0 010", exc_valid, v_ok); end
        tick();
        idle_inputs(); exc_ready = 1'b1;
        to_neg();
        checks++; if (exc_valid !== 1'b1 || exc_chan !== 2'd2 || exc_cause !== 4'd7 || exc_tval !== 32'h60) begin errors++;
            $display("FAIL b2b_second: got valid=%0b chan=%0d cause=%0d tval=%h want 1 2 7 60",
                     exc_valid, exc_chan, exc_cause, exc_tval); end
        tick();
        idle_inputs();
        $display("test_back_to_back done");
    endtask

    task automatic test_saturation();
        idle_inputs(); cnt_clr = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            set_ch(1, 1'b1, 2'b01, 32'(32'h900 + k), 1'b0);
            tick();
            idle_inputs(); exc_ready = 1'b1;
            tick();
        end
        idle_inputs();
        to_neg();
        checks++; if (s_fault_cnt !== 2'd3 || fault_cnt !== 16'd5) begin errors++;
            $display("FAIL sat: got small=%0d wide=%0d want 3 5", s_fault_cnt, fault_cnt); end
        set_ch(0, 1'b1, 2'b11, 32'h70, 1'b0); cnt_clr = 1'b1;
        tick();
        idle_inputs();
        set_ch(2, 1'b1, 2'b01, 32'h74, 1'b0); cnt_clr = 1'b1;
        to_neg();
        checks++; if (s_fault_cnt !== 2'd1 || fault_cnt !== 16'd1 || lost_fault !== 1'b0) begin errors++;
            $display("FAIL clr_capture: got small=%0d wide=%0d lost=%0b want 1 1 0", s_fault_cnt, fault_cnt, lost_fault); end
        tick();
        idle_inputs(); exc_ready = 1'b1;
        to_neg();
        checks++; if (lost_fault !== 1'b1 || fault_cnt !== 16'd0 || s_fault_cnt !== 2'd0) begin errors++;
            $display("FAIL clr_lost: got lost=%0b wide=%0d small=%0d want 1 0 0", lost_fault, fault_cnt, s_fault_cnt); end
        tick();
        idle_inputs();
        $display("test_saturation done");
    endtask

    task automatic test_async_reset();
        idle_inputs();
        set_ch(0, 1'b1, 2'b01, 32'h80, 1'b0);
        tick();
        idle_inputs();
        to_neg();
        checks++; if (exc_valid !== 1'b1) begin errors++; $display("FAIL arst_pre: got %0b want 1", exc_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (exc_valid !== 1'b0 || busy !== 1'b0 || fault_cnt !== 16'd0) begin errors++;
            $display("FAIL arst_drop: got valid=%0b busy=%0b cnt=%0d want 0 0 0", exc_valid, busy, fault_cnt); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            v_req_valid = 3'($urandom);
            for (int i = 0; i < NCH; i++) begin
                v_req_mode[i] = 2'($urandom_range(3));
                v_req_addr[i] = $urandom;
                v_pass[i]     = ($urandom_range(3) != 0);
            end
            flush     = ($urandom_range(7) == 0);
            exc_ready = 1'($urandom_range(1));
            cnt_clr   = ($urandom_range(15) == 0);
            to_neg();
            checks++; if (v_ok !== exp_vok()) begin errors++;
                $display("FAIL rnd_v_ok[%0d]: got %b want %b", n, v_ok, exp_vok()); end
            checks++; if (exc_valid !== m_pend || busy !== m_pend) begin errors++;
                $display("FAIL rnd_valid[%0d]: got valid=%0b busy=%0b want %0b", n, exc_valid, busy, m_pend); end
            checks++; if (fault_cnt !== 16'(m_cnt) || s_fault_cnt !== 2'(m_cnt_s)) begin errors++;
                $display("FAIL rnd_cnt[%0d]: got wide=%0d small=%0d want %0d %0d", n, fault_cnt, s_fault_cnt, m_cnt, m_cnt_s); end
            checks++; if (lost_fault !== m_lost) begin errors++;
                $display("FAIL rnd_lost[%0d]: got %0b want %0b", n, lost_fault, m_lost); end
            if (m_pend) begin
                checks++; if (exc_cause !== m_cause || exc_tval !== m_tval || exc_chan !== m_chan) begin errors++;
                    $display("FAIL rnd_record[%0d]: got cause=%0d tval=%h chan=%0d want %0d %h %0d",
                             n, exc_cause, exc_tval, exc_chan, m_cause, m_tval, m_chan); end
            end
            tick();
        end
        idle_inputs();
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_single_fault();
        test_priority();
        test_busy_lost();
        test_flush();
        test_mode00();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
